// File: rtl/regfile_2r1w_64x24_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w_64x24_ctl
//  Description : Registered port controller for the 64x24 2R1W regfile macro.
//                Turns binary read/write requests into one-hot predecoded
//                address groups, captures read data with write-first bypass,
//                and fills every row with INIT_VAL after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Address bit naming: a0 is the address MSB (adr[5]) and a5 the LSB (adr[0]).
//  Predecode vector layout used internally: {c[1:0], a12[3:0], a3[1:0], a45[3:0]}.
// ============================================================================
module regfile_2r1w_64x24_ctl #(
    parameter bit          INIT_EN  = 1'b1,
    parameter logic [23:0] INIT_VAL = 24'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ready,
    input  logic        rd0_en,
    input  logic [5:0]  rd0_adr,
    output logic [23:0] rd0_dat_o,
    output logic        rd0_vld,
    input  logic        rd1_en,
    input  logic [5:0]  rd1_adr,
    output logic [23:0] rd1_dat_o,
    output logic        rd1_vld,
    input  logic        wr0_en,
    input  logic [5:0]  wr0_adr,
    input  logic [23:0] wr0_dat,
    output logic [1:0]  ar_rd0_c,
    output logic [3:0]  ar_rd0_a12,
    output logic [1:0]  ar_rd0_a3,
    output logic [3:0]  ar_rd0_a45,
    output logic [1:0]  ar_rd1_c,
    output logic [3:0]  ar_rd1_a12,
    output logic [1:0]  ar_rd1_a3,
    output logic [3:0]  ar_rd1_a45,
    output logic [1:0]  ar_wr0_c,
    output logic [3:0]  ar_wr0_a12,
    output logic [1:0]  ar_wr0_a3,
    output logic [3:0]  ar_wr0_a45,
    output logic [23:0] ar_wr0_dat,
    input  logic [23:0] ar_rd0_dat,
    input  logic [23:0] ar_rd1_dat
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] c_LAST_ROW = 6'd63;

    // One-hot predecode of a binary address into the macro's four groups
    function automatic logic [11:0] predec(input logic [5:0] adr);
        logic [1:0] c;
        logic [3:0] a12;
        logic [1:0] a3;
        logic [3:0] a45;
        c   = adr[5] ? 2'b10 : 2'b01;
        a12 = 4'b0001 << adr[4:3];
        a3  = adr[2] ? 2'b10 : 2'b01;
        a45 = 4'b0001 << adr[1:0];
        return {c, a12, a3, a45};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;

    // Registered request bookkeeping used at the capture edge
    logic        rd0_act_q, rd0_act_d;
    logic        rd1_act_q, rd1_act_d;
    logic        wr_act_q, wr_act_d;
    logic [5:0]  rd0_adr_q, rd0_adr_d;
    logic [5:0]  rd1_adr_q, rd1_adr_d;
    logic [5:0]  wr_adr_q, wr_adr_d;
    logic [23:0] wr_dat_q, wr_dat_d;

    // Predecode flops driving the macro directly
    logic [11:0] pd_rd0_q, pd_rd0_d;
    logic [11:0] pd_rd1_q, pd_rd1_d;
    logic [11:0] pd_wr_q, pd_wr_d;

    // Read result registers
    logic [23:0] rd0_dat_q, rd0_dat_d;
    logic [23:0] rd1_dat_q, rd1_dat_d;
    logic        rd0_vld_q, rd0_vld_d;
    logic        rd1_vld_q, rd1_vld_d;

    logic        w_rd0_go, w_rd1_go, w_wr_go;
    logic [5:0]  w_wr_adr;
    logic [23:0] w_wr_dat;

    // Next-state logic: init sequencing, request acceptance, predecode and read capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_wr_go  = 1'b0;
        w_wr_adr = wr0_adr;
        w_wr_dat = wr0_dat;

        case (state_q)
            S_INIT: begin
                // Requests are dropped; the init counter owns the write port
                w_wr_go  = 1'b1;
                w_wr_adr = cnt_q;
                w_wr_dat = INIT_VAL;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == c_LAST_ROW) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_wr_go = ready_q & wr0_en;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        ready_d  = (state_d == S_RUN);

        w_rd0_go = ready_q & rd0_en;
        w_rd1_go = ready_q & rd1_en;

        rd0_act_d = w_rd0_go;
        rd1_act_d = w_rd1_go;
        wr_act_d  = w_wr_go;
        rd0_adr_d = w_rd0_go ? rd0_adr : 6'd0;
        rd1_adr_d = w_rd1_go ? rd1_adr : 6'd0;
        wr_adr_d  = w_wr_go ? w_wr_adr : 6'd0;
        wr_dat_d  = w_wr_go ? w_wr_dat : 24'd0;

        pd_rd0_d = w_rd0_go ? predec(rd0_adr) : 12'd0;
        pd_rd1_d = w_rd1_go ? predec(rd1_adr) : 12'd0;
        pd_wr_d  = w_wr_go ? predec(w_wr_adr) : 12'd0;

        // Capture: a same-address write in the same cycle wins (write-first)
        rd0_vld_d = rd0_act_q;
        rd1_vld_d = rd1_act_q;
        rd0_dat_d = rd0_dat_q;
        rd1_dat_d = rd1_dat_q;
        if (rd0_act_q) begin
            rd0_dat_d = (wr_act_q && (wr_adr_q == rd0_adr_q)) ? wr_dat_q : ar_rd0_dat;
        end
        if (rd1_act_q) begin
            rd1_dat_d = (wr_act_q && (wr_adr_q == rd1_adr_q)) ? wr_dat_q : ar_rd1_dat;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT_EN ? S_INIT : S_RUN;
            cnt_q     <= 6'd0;
            ready_q   <= 1'b0;
            rd0_act_q <= 1'b0;
            rd1_act_q <= 1'b0;
            wr_act_q  <= 1'b0;
            rd0_adr_q <= 6'd0;
            rd1_adr_q <= 6'd0;
            wr_adr_q  <= 6'd0;
            wr_dat_q  <= 24'd0;
            pd_rd0_q  <= 12'd0;
            pd_rd1_q  <= 12'd0;
            pd_wr_q   <= 12'd0;
            rd0_dat_q <= 24'd0;
            rd1_dat_q <= 24'd0;
            rd0_vld_q <= 1'b0;
            rd1_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            rd0_act_q <= rd0_act_d;
            rd1_act_q <= rd1_act_d;
            wr_act_q  <= wr_act_d;
            rd0_adr_q <= rd0_adr_d;
            rd1_adr_q <= rd1_adr_d;
            wr_adr_q  <= wr_adr_d;
            wr_dat_q  <= wr_dat_d;
            pd_rd0_q  <= pd_rd0_d;
            pd_rd1_q  <= pd_rd1_d;
            pd_wr_q   <= pd_wr_d;
            rd0_dat_q <= rd0_dat_d;
            rd1_dat_q <= rd1_dat_d;
            rd0_vld_q <= rd0_vld_d;
            rd1_vld_q <= rd1_vld_d;
        end
    end

    assign ready      = ready_q;
    assign rd0_dat_o  = rd0_dat_q;
    assign rd1_dat_o  = rd1_dat_q;
    assign rd0_vld    = rd0_vld_q;
    assign rd1_vld    = rd1_vld_q;

    assign ar_rd0_c   = pd_rd0_q[11:10];
    assign ar_rd0_a12 = pd_rd0_q[9:6];
    assign ar_rd0_a3  = pd_rd0_q[5:4];
    assign ar_rd0_a45 = pd_rd0_q[3:0];
    assign ar_rd1_c   = pd_rd1_q[11:10];
    assign ar_rd1_a12 = pd_rd1_q[9:6];
    assign ar_rd1_a3  = pd_rd1_q[5:4];
    assign ar_rd1_a45 = pd_rd1_q[3:0];
    assign ar_wr0_c   = pd_wr_q[11:10];
    assign ar_wr0_a12 = pd_wr_q[9:6];
    assign ar_wr0_a3  = pd_wr_q[5:4];
    assign ar_wr0_a45 = pd_wr_q[3:0];
    assign ar_wr0_dat = wr_dat_q;

endmodule
`default_nettype wire
